// File: rtl/cw305_crypt_sequencer_if.sv
// Handshake bundle between the register block / crypto core side (master)
// and the encryption burst sequencer (slave).
interface cw305_crypt_sequencer_if #(
    parameter int pRUN_CNT_WIDTH = 8,
    parameter int pGAP_WIDTH     = 16
);
    logic                      go_i;
    logic                      abort_i;
    logic [pRUN_CNT_WIDTH-1:0] run_count_i;
    logic [pGAP_WIDTH-1:0]     gap_cycles_i;
    logic                      core_ready_i;
    logic                      core_done_i;
    logic                      core_start_o;
    logic                      capture_o;
    logic                      trig_o;
    logic                      busy_o;
    logic                      seq_done_o;
    logic                      timeout_o;
    logic [pRUN_CNT_WIDTH-1:0] runs_done_o;

    modport master (
        output go_i, abort_i, run_count_i, gap_cycles_i, core_ready_i, core_done_i,
        input  core_start_o, capture_o, trig_o, busy_o, seq_done_o, timeout_o, runs_done_o
    );

    modport slave (
        input  go_i, abort_i, run_count_i, gap_cycles_i, core_ready_i, core_done_i,
        output core_start_o, capture_o, trig_o, busy_o, seq_done_o, timeout_o, runs_done_o
    );
endinterface

// File: rtl/cw305_crypt_sequencer.sv
// Encryption burst sequencer: runs N start/done cycles on the crypto core with
// an idle gap between runs, producing capture strobes, a scope trigger window
// and a runs-done count. All outputs are registered.
// Optional watchdog: define CW305_CRYPT_SEQ_TIMEOUT_EN to abort a RUN that
// never sees a done edge within pTIMEOUT_CYCLES cycles.
module cw305_crypt_sequencer #(
    parameter int pRUN_CNT_WIDTH = 8,
    parameter int pGAP_WIDTH     = 16
`ifdef CW305_CRYPT_SEQ_TIMEOUT_EN
    ,
    parameter int pTIMEOUT_WIDTH = 24,
    parameter logic [pTIMEOUT_WIDTH-1:0] pTIMEOUT_CYCLES = 24'd1000000
`endif
) (
    input  logic                     crypto_clk,
    input  logic                     reset_n,
    cw305_crypt_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT_RDY, RUN, GAP} state_t;

    localparam logic [pRUN_CNT_WIDTH-1:0] RUN_ONE = {{(pRUN_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pRUN_CNT_WIDTH-1:0] RUN_MAX = {pRUN_CNT_WIDTH{1'b1}};
    localparam logic [pGAP_WIDTH-1:0]     GAP_ONE = {{(pGAP_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state_reg, state_next;
    logic                      done_q_reg;
    logic                      done_edge;
    logic [pRUN_CNT_WIDTH-1:0] target_reg;
    logic [pGAP_WIDTH-1:0]     gap_reg;
    logic [pGAP_WIDTH-1:0]     gap_cnt_reg;
    logic [pRUN_CNT_WIDTH-1:0] runs_done_reg, runs_done_next, runs_done_inc;
    logic                      start_reg, start_next;
    logic                      capture_reg, capture_next;
    logic                      trig_reg, trig_next;
    logic                      busy_reg, busy_next;
    logic                      seq_done_reg, seq_done_next;
    logic                      go_accept, done_accept, last_run, timeout_hit, wd_expired;

    // Only a rising edge of done counts, so a done held over from a previous run is ignored.
    assign done_edge     = bus.core_done_i & ~done_q_reg;
    assign runs_done_inc = (runs_done_reg == RUN_MAX) ? runs_done_reg : runs_done_reg + 1'b1;
    assign last_run      = (runs_done_inc == target_reg);

    // State register, latched configuration, gap countdown and registered outputs.
    always_ff @(posedge crypto_clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            done_q_reg    <= 1'b0;
            target_reg    <= RUN_ONE;
            gap_reg       <= '0;
            gap_cnt_reg   <= '0;
            runs_done_reg <= '0;
            start_reg     <= 1'b0;
            capture_reg   <= 1'b0;
            trig_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            seq_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            done_q_reg    <= bus.core_done_i;
            runs_done_reg <= runs_done_next;
            start_reg     <= start_next;
            capture_reg   <= capture_next;
            trig_reg      <= trig_next;
            busy_reg      <= busy_next;
            seq_done_reg  <= seq_done_next;
            if (go_accept) begin
                target_reg <= (bus.run_count_i == '0) ? RUN_ONE : bus.run_count_i;
                gap_reg    <= bus.gap_cycles_i;
            end
            if (done_accept && !last_run) begin
                gap_cnt_reg <= gap_reg;
            end else if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
        end
    end

    // Next-state decision; abort overrides everything, an accepted done beats the watchdog.
    always_comb begin
        state_next  = state_reg;
        go_accept   = 1'b0;
        done_accept = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.go_i && !bus.abort_i) begin
                    go_accept  = 1'b1;
                    state_next = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bus.abort_i)           state_next = IDLE;
                else if (bus.core_ready_i) state_next = RUN;
            end
            RUN: begin
                if (bus.abort_i) begin
                    state_next = IDLE;
                end else if (done_edge && !start_reg) begin
                    done_accept = 1'b1;
                    if (last_run)           state_next = IDLE;
                    else if (gap_reg == '0) state_next = WAIT_RDY;
                    else                    state_next = GAP;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            GAP: begin
                if (bus.abort_i)                 state_next = IDLE;
                else if (gap_cnt_reg <= GAP_ONE) state_next = WAIT_RDY;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the transition being taken.
    always_comb begin
        start_next     = (state_reg == WAIT_RDY) && (state_next == RUN);
        trig_next      = (state_next == RUN);
        busy_next      = (state_next != IDLE);
        capture_next   = done_accept;
        seq_done_next  = (done_accept && last_run) || timeout_hit;
        runs_done_next = runs_done_reg;
        if (go_accept)        runs_done_next = '0;
        else if (done_accept) runs_done_next = runs_done_inc;
    end

`ifdef CW305_CRYPT_SEQ_TIMEOUT_EN
    localparam logic [pTIMEOUT_WIDTH-1:0] WD_LAST = pTIMEOUT_CYCLES - 1'b1;

    logic [pTIMEOUT_WIDTH-1:0] wd_reg;
    logic                      timeout_reg;

    // wd_reg holds the number of RUN cycles already completed in this run.
    assign wd_expired = (wd_reg == WD_LAST);

    // Watchdog counts RUN cycles; the sticky flag clears only on an accepted go.
    always_ff @(posedge crypto_clk) begin
        if (!reset_n) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_reg <= (state_reg == RUN) ? wd_reg + 1'b1 : '0;
            if (go_accept)        timeout_reg <= 1'b0;
            else if (timeout_hit) timeout_reg <= 1'b1;
        end
    end

    assign bus.timeout_o = timeout_reg;
`else
    assign wd_expired    = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.core_start_o = start_reg;
    assign bus.capture_o    = capture_reg;
    assign bus.trig_o       = trig_reg;
    assign bus.busy_o       = busy_reg;
    assign bus.seq_done_o   = seq_done_reg;
    assign bus.runs_done_o  = runs_done_reg;
endmodule
